// File: rtl/pattern_detector_mc.sv
// ---------------------------------------------------------------------------
// pattern_detector_mc
//
// Watches CHANNELS independent serial bit streams for the compile-time bit
// pattern PATTERN (PAT_LEN bits, MSB received first). Each channel produces a
// registered one-cycle match pulse on z[i] and keeps a saturating hit counter.
// OVERLAP=1 keeps history after a match so overlapping occurrences also fire.
// OVERLAP=0 discards history after a match.
//
// Ports:
//   my_clk       - sole clock, rising edge
//   global_reset - synchronous active-high reset (overrides everything else)
//   en           - sample enable shared by all channels
//   x            - serial data, bit i belongs to channel i
//   clr_count    - synchronous clear of all hit counters (wins over increment)
//   z            - registered match pulses, one bit per channel
//   hit_count    - per-channel counters, channel i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module pattern_detector_mc #(
  parameter int                 CHANNELS = 4,
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1011,
  parameter bit                 OVERLAP  = 1'b1,
  parameter int                 CNT_W    = 8
) (
  input  logic                      my_clk,
  input  logic                      global_reset,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       x,
  input  logic                      clr_count,
  output logic [CHANNELS-1:0]       z,
  output logic [CHANNELS*CNT_W-1:0] hit_count
);

  // fill counts 0..PAT_LEN, so it needs enough bits to hold PAT_LEN itself
  localparam int               FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] hist_r     [CHANNELS];
  logic [FILL_W-1:0]  fill_r     [CHANNELS];
  logic [CNT_W-1:0]   cnt_r      [CHANNELS];
  logic [CHANNELS-1:0] z_r;

  logic [PAT_LEN-1:0] new_hist_s [CHANNELS];
  logic [FILL_W-1:0]  new_fill_s [CHANNELS];
  logic [CHANNELS-1:0] match_s;

  // Shift one bit into the history; the concatenation-then-truncate form also
  // covers PAT_LEN=1, where the new history is just the incoming bit.
  function automatic logic [PAT_LEN-1:0] shift_in(input logic [PAT_LEN-1:0] h,
                                                   input logic b);
    return PAT_LEN'({h, b});
  endfunction

  // Next history/fill and match decision per channel
  always_comb begin
    match_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      new_hist_s[i] = shift_in(hist_r[i], x[i]);
      if (fill_r[i] == FILL_FULL) begin
        new_fill_s[i] = FILL_FULL;
      end else begin
        new_fill_s[i] = fill_r[i] + FILL_W'(1);
      end
      // fill gating stops stale/power-up history from forming a false match
      match_s[i] = en && (new_fill_s[i] == FILL_FULL) && (new_hist_s[i] == PATTERN);
    end
  end

  // Per-channel history, fill, match pulse and hit counter registers
  always_ff @(posedge my_clk) begin
    if (global_reset) begin
      z_r <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hist_r[i] <= '0;
        fill_r[i] <= '0;
        cnt_r[i]  <= '0;
      end
    end else begin
      // match_s already includes en, so z drops to 0 whenever en is low
      z_r <= match_s;
      for (int i = 0; i < CHANNELS; i++) begin
        if (en) begin
          if (match_s[i] && !OVERLAP) begin
            hist_r[i] <= '0;
            fill_r[i] <= '0;
          end else begin
            hist_r[i] <= new_hist_s[i];
            fill_r[i] <= new_fill_s[i];
          end
        end else begin
          hist_r[i] <= hist_r[i];
          fill_r[i] <= fill_r[i];
        end

        if (clr_count) begin
          cnt_r[i] <= '0;
        end else if (match_s[i] && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign z = z_r;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_cnt_out
      assign hit_count[g*CNT_W +: CNT_W] = cnt_r[g];
    end
  endgenerate

endmodule

// File: tb/tb_pattern_detector_mc.sv
// ---------------------------------------------------------------------------
// tb_pattern_detector_mc
//
// Directed bench for pattern_detector_mc with PATTERN=4'b1011, PAT_LEN=4.
// Three instances share all stimulus:
//   dut_ov  : OVERLAP=1, CNT_W=8
//   dut_no  : OVERLAP=0, CNT_W=8
//   dut_sat : OVERLAP=0, CNT_W=2 (counter saturation)
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_pattern_detector_mc;

  logic       my_clk = 1'b0;
  logic       global_reset;
  logic       en;
  logic [3:0] x;
  logic       clr_count;

  logic [3:0]  z_ov, z_no, z_sat;
  logic [31:0] hc_ov, hc_no;
  logic [7:0]  hc_sat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 my_clk = ~my_clk;

  pattern_detector_mc #(.CHANNELS(4), .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .my_clk(my_clk), .global_reset(global_reset), .en(en), .x(x),
    .clr_count(clr_count), .z(z_ov), .hit_count(hc_ov));

  pattern_detector_mc #(.CHANNELS(4), .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
    .my_clk(my_clk), .global_reset(global_reset), .en(en), .x(x),
    .clr_count(clr_count), .z(z_no), .hit_count(hc_no));

  pattern_detector_mc #(.CHANNELS(4), .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) dut_sat (
    .my_clk(my_clk), .global_reset(global_reset), .en(en), .x(x),
    .clr_count(clr_count), .z(z_sat), .hit_count(hc_sat));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one set of inputs across a rising edge, then settle past it.
  task automatic drive(input logic e, input logic [3:0] xv, input logic c, input logic r);
    global_reset = r;
    en           = e;
    x            = xv;
    clr_count    = c;
    @(posedge my_clk);
    #1;
  endtask

  // Feed n bits (MSB first) on channel 0 with en=1 and check z of every
  // instance after each edge against the expected pulse patterns.
  task automatic feed(input string tag, input logic [31:0] bits, input int n,
                      input logic [31:0] exp_ov, input logic [31:0] exp_no);
    for (int k = n - 1; k >= 0; k--) begin
      drive(1'b1, {3'b000, bits[k]}, 1'b0, 1'b0);
      check_eq($sformatf("%s_zov_s%0d", tag, n - k), {28'd0, z_ov},  {31'd0, exp_ov[k]});
      check_eq($sformatf("%s_zno_s%0d", tag, n - k), {28'd0, z_no},  {31'd0, exp_no[k]});
      check_eq($sformatf("%s_zsat_s%0d", tag, n - k), {28'd0, z_sat}, {31'd0, exp_no[k]});
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b1111, 1'b1, 1'b1);
  endtask

  initial begin
    global_reset = 1'b0;
    en           = 1'b0;
    x            = 4'b0000;
    clr_count    = 1'b0;
    @(posedge my_clk);
    #1;

    // 1. reset values (reset overrides en/x/clr_count), then basic match
    do_reset();
    check_eq("rst_z_ov",  {28'd0, z_ov},  32'd0);
    check_eq("rst_z_no",  {28'd0, z_no},  32'd0);
    check_eq("rst_z_sat", {28'd0, z_sat}, 32'd0);
    check_eq("rst_hc_ov", hc_ov, 32'd0);
    check_eq("rst_hc_no", hc_no, 32'd0);
    check_eq("rst_hc_sat", {24'd0, hc_sat}, 32'd0);
    feed("basic", 32'b1011, 4, 32'b0001, 32'b0001);
    check_eq("basic_cnt0_ov", {24'd0, hc_ov[7:0]}, 32'd1);
    check_eq("basic_cnt_ov_others", {8'd0, hc_ov[31:8]}, 32'd0);
    check_eq("basic_cnt0_no", {24'd0, hc_no[7:0]}, 32'd1);

    // 2. overlap vs non-overlap
    do_reset();
    feed("ovl", 32'b1011011, 7, 32'b0001001, 32'b0001000);
    check_eq("ovl_cnt0_ov", {24'd0, hc_ov[7:0]}, 32'd2);
    check_eq("ovl_cnt0_no", {24'd0, hc_no[7:0]}, 32'd1);
    do_reset();
    feed("ovl2", 32'b10111011, 8, 32'b00010001, 32'b00010001);
    check_eq("ovl2_cnt0_no", {24'd0, hc_no[7:0]}, 32'd2);

    // 3. pattern split across an en=0 gap
    do_reset();
    feed("gap_a", 32'b10, 2, 32'b00, 32'b00);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b0000, 1'b0, 1'b0);
      check_eq($sformatf("gap_zov_off%0d", k), {28'd0, z_ov}, 32'd0);
      check_eq($sformatf("gap_zno_off%0d", k), {28'd0, z_no}, 32'd0);
    end
    feed("gap_b", 32'b11, 2, 32'b01, 32'b01);
    check_eq("gap_cnt0_ov", {24'd0, hc_ov[7:0]}, 32'd1);

    // 4. saturation at 3 for CNT_W=2, then clear on the edge of a 6th match
    do_reset();
    feed("sat", 32'hBBBBB, 20, 32'h11111, 32'h11111);
    check_eq("sat_cnt0_sat", {24'd0, hc_sat}, 32'd3);
    check_eq("sat_cnt0_no",  {24'd0, hc_no[7:0]}, 32'd5);
    check_eq("sat_cnt0_ov",  {24'd0, hc_ov[7:0]}, 32'd5);
    feed("clr_pre", 32'b101, 3, 32'b000, 32'b000);
    drive(1'b1, 4'b0001, 1'b1, 1'b0);
    check_eq("clr_z_ov",  {28'd0, z_ov},  32'd1);
    check_eq("clr_z_sat", {28'd0, z_sat}, 32'd1);
    check_eq("clr_cnt_ov",  hc_ov, 32'd0);
    check_eq("clr_cnt_sat", {24'd0, hc_sat}, 32'd0);

    // 5. reset mid-pattern discards history
    do_reset();
    feed("mid_a", 32'b101, 3, 32'b000, 32'b000);
    do_reset();
    check_eq("mid_rst_z", {28'd0, z_ov}, 32'd0);
    feed("mid_b", 32'b1, 1, 32'b0, 32'b0);
    feed("mid_c", 32'b1011, 4, 32'b0001, 32'b0001);
    check_eq("mid_cnt0_ov", {24'd0, hc_ov[7:0]}, 32'd1);
    check_eq("mid_cnt0_no", {24'd0, hc_no[7:0]}, 32'd1);

    // 6. channel independence: ch0 = 1011, ch1 = 1010
    do_reset();
    drive(1'b1, 4'b0011, 1'b0, 1'b0);
    drive(1'b1, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    check_eq("chan_z_ov", {28'd0, z_ov}, 32'd1);
    check_eq("chan_z_no", {28'd0, z_no}, 32'd1);
    check_eq("chan_cnt_ov", hc_ov, 32'h0000_0001);
    check_eq("chan_cnt1_no", {24'd0, hc_no[15:8]}, 32'd0);
    drive(1'b1, 4'b0000, 1'b0, 1'b0);
    check_eq("chan_z_after", {28'd0, z_ov}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_detector_mc.md
# pattern_detector_mc

Multi-channel serial pattern detector: the parametrised successor of the single-input, single-output HelloWorld sequence detector. It watches CHANNELS independent serial bit streams for a compile-time bit pattern of configurable length, with selectable overlapping or non-overlapping matching. For each channel it emits a registered one-cycle match pulse and keeps a saturating hit counter. It sits between the input pads and downstream logic in the same clock domain as the HelloWorld block.

## Interface
Parameters:
- CHANNELS, 4: number of independent serial inputs (1..16).
- PAT_LEN, 4: pattern length in bits (1..32).
- PATTERN, 4'b1011: pattern, PAT_LEN bits wide. The MSB is the first bit received.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = history is discarded after each match.
- CNT_W, 8: width of each per-channel hit counter (≥1).

Ports:
- my_clk, input, 1: sole clock. All state updates on the rising edge.
- global_reset, input, 1: synchronous, active-high reset.
- en, input, 1: sample enable, shared by all channels.
- x, input, CHANNELS: serial data. Bit i belongs to channel i.
- clr_count, input, 1: synchronous clear of all hit counters.
- z, output, CHANNELS: registered match pulses, one bit per channel.
- hit_count, output, CHANNELS*CNT_W: channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
Each channel keeps three registers:
- hist: PAT_LEN-bit history shift register.
- fill: count of valid history bits, 0..PAT_LEN, saturating at PAT_LEN.
- cnt: CNT_W-bit hit counter.

Reset (global_reset=1 at a clock edge):
- hist, fill, z and every cnt are set to 0.
- global_reset overrides en, x and clr_count.
- Reset mid-pattern discards all partial history.

Sampling, on each edge with en=1:
- new_hist = {hist[PAT_LEN-2:0], x[i]}. For PAT_LEN=1, new_hist = x[i].
- new_fill = min(fill+1, PAT_LEN).
- match = (new_fill == PAT_LEN) && (new_hist == PATTERN).
- On match with OVERLAP=1: hist←new_hist, fill←PAT_LEN.
- On match with OVERLAP=0: hist←0, fill←0.
- With no match: hist←new_hist, fill←new_fill.
- z[i]←match.

Enable low, on each edge with en=0:
- hist and fill hold.
- z←0.
- A pattern split across en=0 gaps still matches.

Counters:
- On match, cnt increments by 1 and saturates at 2^CNT_W−1. It never wraps.
- clr_count=1 sets every cnt to 0. This takes priority over a simultaneous increment.
- The z pulse on that same edge is still produced.

Channel independence: channels share only en, clr_count and reset. A match on one channel never affects another.

Note: fill gating prevents false matches on power-up zeros, e.g. PATTERN=4'b0000 does not fire after only 2 zeros.

## Timing
- Latency: z[i] goes high at the same edge that samples the final pattern bit and stays high for exactly one cycle, unless the next sample is also a match (possible with OVERLAP=1 and periodic patterns, e.g. PATTERN=2'b11 on a stream of ones).
- hit_count updates at the same edge as z and is registered.
- Reset values: z=0, hit_count=0, available the cycle after the reset edge.
- No combinational path from any input to any output.

## Test plan
All scenarios use PATTERN=4'b1011 and PAT_LEN=4 unless noted.

1. Basic match and reset values: assert reset, release, en=1, drive x[0]=1,0,1,1.
   - After reset: z=0, all counts 0.
   - z[0]=1 only in the cycle after the 4th sample edge; count0=1; z[3:1]=0.
2. Overlap modes, x[0]=1,0,1,1,0,1,1:
   - OVERLAP=1: z[0] pulses after samples 4 and 7; count0=2.
   - OVERLAP=0: one pulse after sample 4; count0=1.
   - OVERLAP=0 with 1,0,1,1,1,0,1,1: pulses after samples 4 and 8.
3. Enable gaps: x[0]=1,0 with en=1; then 5 cycles of en=0 with x[0]=0; then x[0]=1,1 with en=1.
   - z[0] pulses after the final sample.
   - z stays 0 throughout the en=0 cycles.
4. Saturation and clear:
   - CNT_W=2, 5 non-overlapping matches → count0=3, no wrap.
   - clr_count=1 on the edge of a 6th match → z[0]=1 and count0=0.
5. Reset mid-pattern: x[0]=1,0,1, then reset for one edge, then x[0]=1 → no pulse. A subsequent 1,0,1,1 → pulse, count0=1.
6. Channel independence: x[0] carries 1011 while x[1] carries 1010 on the same cycles → z[0]=1, z[1]=0; count1 remains 0.
